// File: rtl/ahb_sram_if_if.sv
// AHB-Lite bus bundle between a master/interconnect and the ahb_sram_if slave.
// hready_in is the interconnect's combined hready, hence it sits on the master side.
interface ahb_sram_if_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
        input  hready_out, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
        output hready_out, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_if.sv
// AHB-Lite slave that serialises byte/half/word transfers into single-byte SRAM cycles.
// Define AHB_SRAM_ERR_EN to answer BIST-owned, oversized, misaligned or out-of-range accesses with ERROR.
module ahb_sram_if #(
    parameter int SRAM_AW = 13,
    parameter int RD_LAT  = 1
) (
    input  logic               i_hclk,
    input  logic               i_hresetn,
    ahb_sram_if_if.slave       ahb,
    input  logic               i_bist_ten,
    output logic [SRAM_AW-1:0] o_addr_fun,
    output logic               o_cen_fun,
    output logic               o_wen_fun,
    output logic               o_oen_fun,
    output logic [7:0]         o_wdata_fun,
    input  logic [7:0]         i_rdata_fun
);
    localparam int CW = $clog2(RD_LAT + 5);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_ERR1, S_ERR2} state_t;

    state_t             r_state, w_state_nxt, w_start;
    logic [CW-1:0]      r_cyc, r_n, w_n, w_cap_idx;
    logic [SRAM_AW-1:0] r_addr_fun, w_addr_al, w_mask;
    logic [1:0]         r_lane0, w_sz, w_cap_lane;
    logic               r_bist;
    logic [7:0]         r_wdata_fun, w_wr_byte, w_cap_byte;
    logic [31:0]        r_rdbuf, r_hrdata, w_rd_result;
    logic [7:0]         w_hwdata_lane [4];
    logic               w_err, w_accept, w_hready, w_issue, w_last_issue, w_rd_done, w_cap;
    logic               w_cen, w_wen, w_oen;
    logic [1:0]         w_hresp;
    logic               w_unused;

    // Address-phase decode: oversized transfers behave as words, address aligned to the size.
    assign w_sz      = (ahb.hsize > 3'd2) ? 2'd2 : ahb.hsize[1:0];
    assign w_n       = CW'(1) << w_sz;
    assign w_mask    = {{(SRAM_AW-2){1'b0}}, (w_sz == 2'd2), (w_sz != 2'd0)};
    assign w_addr_al = ahb.haddr[SRAM_AW-1:0] & ~w_mask;
    assign w_unused  = ^{ahb.haddr[31:SRAM_AW], ahb.htrans[0]};

`ifdef AHB_SRAM_ERR_EN
    assign w_err = i_bist_ten | (ahb.hsize > 3'd2) | (|(ahb.haddr[1:0] & w_mask[1:0]))
                 | (|ahb.haddr[31:SRAM_AW]);
`else
    assign w_err = 1'b0;
`endif

    assign w_start  = w_err ? S_ERR1 : (ahb.hwrite ? S_WR : S_RD);
    assign w_accept = ahb.hsel & ahb.hready_in & ahb.htrans[1] & w_hready;

    // r_cyc counts data-phase cycles from 0; issues occupy 0..N-1, captures trail by RD_LAT.
    assign w_issue      = (r_cyc < r_n);
    assign w_last_issue = (r_cyc == r_n - CW'(1));
    assign w_rd_done    = (r_cyc == r_n - CW'(1) + CW'(RD_LAT));
    assign w_cap        = (r_state == S_RD) && (r_cyc >= CW'(RD_LAT));
    assign w_cap_idx    = r_cyc - CW'(RD_LAT);
    assign w_cap_lane   = r_lane0 + w_cap_idx[1:0];
    assign w_cap_byte   = r_bist ? 8'h00 : i_rdata_fun;
    assign w_wr_byte    = w_hwdata_lane[r_addr_fun[1:0]];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_hwdata_lane[gi] = ahb.hwdata[8*gi +: 8];
            assign w_rd_result[8*gi +: 8] = (w_cap && (w_cap_lane == 2'(gi))) ? w_cap_byte
                                                                             : r_rdbuf[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        unique case (r_state)
            S_WR:    w_hready = w_last_issue;
            S_RD:    w_hready = w_rd_done;
            S_ERR1:  w_hready = 1'b0;
            default: w_hready = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cen       = 1'b1;
        w_wen       = 1'b1;
        w_oen       = 1'b1;
        w_hresp     = 2'b00;
        unique case (r_state)
            S_WR: begin
                w_cen = r_bist;
                w_wen = r_bist;
            end
            S_RD: begin
                if (w_issue) begin
                    w_cen = r_bist;
                    w_oen = r_bist;
                end
            end
            S_ERR1: begin
                w_hresp     = 2'b01;
                w_state_nxt = S_ERR2;
            end
            S_ERR2:  w_hresp = 2'b01;
            default: ;
        endcase
        // Every ready cycle is also an address-phase slot, so back-to-back needs no idle gap.
        if (w_hready) begin
            w_state_nxt = w_accept ? w_start : S_IDLE;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_n         <= '0;
            r_addr_fun  <= '0;
            r_lane0     <= '0;
            r_bist      <= 1'b0;
            r_wdata_fun <= '0;
            r_rdbuf     <= '0;
            r_hrdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_WR) begin
                r_wdata_fun <= w_wr_byte;
            end
            if ((r_state == S_RD) && w_rd_done) begin
                r_hrdata <= w_rd_result;
            end
            if (w_accept) begin
                r_cyc   <= '0;
                r_n     <= w_n;
                r_lane0 <= w_addr_al[1:0];
                r_bist  <= i_bist_ten;
                r_rdbuf <= '0;
                if (!w_err) begin
                    r_addr_fun <= w_addr_al;
                end
            end else if ((r_state == S_WR) || (r_state == S_RD)) begin
                r_cyc <= r_cyc + CW'(1);
                if (w_cap) begin
                    r_rdbuf <= w_rd_result;
                end
                if (w_issue && !w_last_issue) begin
                    r_addr_fun <= r_addr_fun + SRAM_AW'(1);
                end
            end
        end
    end

    assign ahb.hready_out = w_hready;
    assign ahb.hresp      = w_hresp;
    assign ahb.hrdata     = ((r_state == S_RD) && w_rd_done) ? w_rd_result : r_hrdata;
    assign o_addr_fun     = r_addr_fun;
    assign o_cen_fun      = w_cen;
    assign o_wen_fun      = w_wen;
    assign o_oen_fun      = w_oen;
    assign o_wdata_fun    = (r_state == S_WR) ? w_wr_byte : r_wdata_fun;
endmodule
